// File: rtl/stopwatch_counter_if.sv
// Operator controls and display outputs of the count-up stopwatch.
// The master side drives the target and button events; the slave side is the counter.
interface stopwatch_counter_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] in;
    logic             start_ev;
    logic             pause_ev;
    logic             restart_ev;
    logic             lap_ev;
    logic [WIDTH-1:0] count;
    logic             LED;
    logic             running;
    logic [WIDTH-1:0] lap_val;
    logic             lap_valid;

    modport master (
        output in, start_ev, pause_ev, restart_ev, lap_ev,
        input  count, LED, running, lap_val, lap_valid
    );

    modport slave (
        input  in, start_ev, pause_ev, restart_ev, lap_ev,
        output count, LED, running, lap_val, lap_valid
    );
endinterface

// File: rtl/stopwatch_counter.sv
// Count-up stopwatch: counts 1 Hz ticks from 0 to a latched target, then flashes LED.
// Optional lap register is built only when LAP_CAPTURE_EN is defined.
module stopwatch_counter #(
    parameter int WIDTH     = 6,
    parameter int MAX_COUNT = 63
) (
    input logic                newclk,
    input logic                my_reset,
    stopwatch_counter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);

    state_t           state, state_n;
    logic [WIDTH-1:0] count, count_n;
    logic [WIDTH-1:0] target, target_n;
    logic             led, led_n;
    logic             running;
    logic             clr_lap;

    always_ff @(posedge newclk or posedge my_reset) begin
        if (my_reset) begin
            state   <= IDLE;
            count   <= '0;
            target  <= '0;
            led     <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            target  <= target_n;
            led     <= led_n;
            running <= (state_n == RUN);
        end
    end

    // restart outranks pause, which outranks start
    always_comb begin
        state_n  = state;
        count_n  = count;
        target_n = target;
        led_n    = led;
        clr_lap  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start_ev) begin
                    state_n  = RUN;
                    count_n  = '0;
                    target_n = (bus.in == '0) ? MAX_W : bus.in;
                end
            end
            RUN: begin
                if (bus.restart_ev) begin
                    count_n = '0;
                    led_n   = 1'b0;
                    clr_lap = 1'b1;
                end else if (bus.pause_ev) begin
                    state_n = PAUSE;
                end else if (count == target) begin
                    state_n = DONE;
                    led_n   = 1'b1;
                end else begin
                    count_n = count + 1'b1;
                end
            end
            PAUSE: begin
                if (bus.restart_ev) begin
                    state_n = RUN;
                    count_n = '0;
                    led_n   = 1'b0;
                    clr_lap = 1'b1;
                end else if (bus.start_ev) begin
                    state_n = RUN;
                end
            end
            DONE: begin
                if (bus.restart_ev) begin
                    state_n = RUN;
                    count_n = '0;
                    led_n   = 1'b0;
                    clr_lap = 1'b1;
                end else begin
                    led_n = ~led;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.count   = count;
    assign bus.LED     = led;
    assign bus.running = running;

`ifdef LAP_CAPTURE_EN
    logic [WIDTH-1:0] lap_val;
    logic             lap_valid;
    logic             lap_ok;

    assign lap_ok = (state == RUN) || (state == PAUSE);

    always_ff @(posedge newclk or posedge my_reset) begin
        if (my_reset) begin
            lap_val   <= '0;
            lap_valid <= 1'b0;
        end else if (clr_lap) begin
            lap_valid <= 1'b0;
        end else if (bus.lap_ev && lap_ok) begin
            lap_val   <= count;
            lap_valid <= 1'b1;
        end
    end

    assign bus.lap_val   = lap_val;
    assign bus.lap_valid = lap_valid;
`else
    logic lap_unused;
    assign lap_unused    = bus.lap_ev ^ clr_lap;
    assign bus.lap_val   = '0;
    assign bus.lap_valid = 1'b0;
`endif
endmodule
